// File: rtl/app_mult_arbiter.sv
// Round-robin arbiter that shares one multiplier core between two requesters.
// Each granted operation holds mult_en for MULT_LAT cycles, then returns the product with a one-cycle valid pulse.
module app_mult_arbiter #(
    parameter int WIDTH1   = 8,
    parameter int WIDTH2   = 8,
    parameter int MULT_LAT = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     req0_valid,
    input  logic [WIDTH1-1:0]        req0_a,
    input  logic [WIDTH2-1:0]        req0_b,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [WIDTH1-1:0]        req1_a,
    input  logic [WIDTH2-1:0]        req1_b,
    output logic                     req1_ready,
    output logic                     rsp0_valid,
    output logic                     rsp1_valid,
    output logic [WIDTH1+WIDTH2-1:0] rsp_data,
    output logic                     mult_en,
    output logic [WIDTH1-1:0]        mult_a,
    output logic [WIDTH2-1:0]        mult_b,
    output logic                     mult_cin,
    input  logic [WIDTH1+WIDTH2-1:0] mult_sum
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          grant_id;
    logic          grant_any;
    logic          grant_sel;

    // On a tie the requester that did not win last time gets the core.
    always_comb begin
        grant_any = req0_valid || req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && grant_any && !grant_sel;
    assign req1_ready = (state == IDLE) && grant_any &&  grant_sel;
    assign mult_cin   = 1'b0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            mult_en    <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    mult_en    <= 1'b0;
                    if (grant_any) begin
                        mult_a     <= grant_sel ? req1_a : req0_a;
                        mult_b     <= grant_sel ? req1_b : req0_b;
                        grant_id   <= grant_sel;
                        last_grant <= grant_sel;
                        cnt        <= '0;
                        mult_en    <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // The core output is valid by the last enabled cycle, so capture it on that edge.
                    if (cnt == CNT_LAST) begin
                        rsp_data   <= mult_sum;
                        mult_en    <= 1'b0;
                        rsp0_valid <= ~grant_id;
                        rsp1_valid <=  grant_id;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_app_mult_arbiter.sv
// Scoreboard bench for app_mult_arbiter with an exact multiplier core model.
// Requester tasks push expected responses at handshake; a negedge monitor pops and compares.
module tb_app_mult_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data;
    logic        mult_en;
    logic [7:0]  mult_a, mult_b;
    logic        mult_cin;
    logic [15:0] mult_sum;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t resp_q[$];
    int   grant_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   en_len   = 0;
    int   hs_cyc[2];
    logic [7:0] burst_a, burst_b;

    app_mult_arbiter #(.WIDTH1(8), .WIDTH2(8), .MULT_LAT(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_cin(mult_cin),
        .mult_sum(mult_sum)
    );

    // Exact core model; the arbiter must pass its output through untouched.
    assign mult_sum = {8'd0, mult_a} * {8'd0, mult_b};

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("[TB] FAIL %s: event not expected or never arrived", name);
    endtask

    task automatic apply_stimulus(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] expd);
        int  waited = 0;
        bit  done   = 0;
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        while (!done) begin
            @(negedge sys_clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                resp_q.push_back('{id: id, a: a, b: b, data: expd, cyc: cyc});
                done = 1;
            end else if (++waited > 200) begin
                fail_now("handshake_timeout");
                done = 1;
            end
        end
        @(posedge sys_clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((resp_q.size() != 0) && (waited < 60)) begin
            @(negedge sys_clk);
            waited++;
        end
        if (resp_q.size() != 0) fail_now("drain_timeout");
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: grants, responses and enable bursts are checked against bench expectations.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst_n) begin
            en_len = 0;
        end else begin
            if (req0_ready || req1_ready) begin
                check_output("ready_exclusive",
                             {29'd0, req0_ready && req1_ready, mult_en, rsp0_valid || rsp1_valid}, 32'd0);
                hs_cyc[req1_ready ? 1 : 0] = cyc;
                if (grant_q.size() == 0) fail_now("unexpected_grant");
                else check_output("grant_order", {31'd0, req1_ready}, grant_q.pop_front());
            end
            if (rsp0_valid || rsp1_valid) begin
                if (resp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = resp_q.pop_front();
                    check_output("rsp_single", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
                    check_output("rsp_id", {31'd0, rsp1_valid}, e.id);
                    check_output("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    check_output("rsp_latency", cyc - e.cyc, 32'd5);
                    check_output("en_low_in_resp", {31'd0, mult_en}, 32'd0);
                end
            end
            if (mult_en) begin
                if (en_len == 0) begin
                    burst_a = mult_a;
                    burst_b = mult_b;
                    check_output("mult_cin", {31'd0, mult_cin}, 32'd0);
                    if (resp_q.size() != 0) begin
                        check_output("mult_a", {24'd0, mult_a}, {24'd0, resp_q[0].a});
                        check_output("mult_b", {24'd0, mult_b}, {24'd0, resp_q[0].b});
                    end
                end else begin
                    check_output("mult_a_stable", {24'd0, mult_a}, {24'd0, burst_a});
                    check_output("mult_b_stable", {24'd0, mult_b}, {24'd0, burst_b});
                end
                en_len = en_len + 1;
            end else if (en_len != 0) begin
                check_output("en_burst_len", en_len, 32'd4);
                en_len = 0;
            end
        end
    end

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        check_output("reset_mult_en", {31'd0, mult_en}, 32'd0);
        check_output("reset_mult_ab", {16'd0, mult_a, mult_b}, 32'd0);
        check_output("reset_mult_cin", {31'd0, mult_cin}, 32'd0);
        check_output("reset_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check_output("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check_output("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Single operation from requester 0.
        grant_q.push_back(0);
        apply_stimulus(0, 8'd25, 8'd13, 16'd325);
        wait_drain();

        // Full-scale operands from requester 1; leaves last_grant at 1.
        grant_q.push_back(1);
        apply_stimulus(1, 8'd255, 8'd255, 16'd65025);
        wait_drain();

        // Contention from the same cycle: requester 0 first, requester 1 six cycles later.
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            apply_stimulus(0, 8'd3, 8'd7, 16'd21);
            apply_stimulus(1, 8'd10, 8'd20, 16'd200);
        join
        wait_drain();
        check_output("contention_spacing", hs_cyc[1] - hs_cyc[0], 32'd6);

        // Both requesters continuously valid: strict alternation.
        for (int i = 0; i < 6; i++) grant_q.push_back(i % 2);
        fork
            begin
                apply_stimulus(0, 8'd1, 8'd2, 16'd2);
                apply_stimulus(0, 8'd4, 8'd4, 16'd16);
                apply_stimulus(0, 8'd9, 8'd11, 16'd99);
            end
            begin
                apply_stimulus(1, 8'd12, 8'd12, 16'd144);
                apply_stimulus(1, 8'd100, 8'd3, 16'd300);
                apply_stimulus(1, 8'd128, 8'd2, 16'd256);
            end
        join
        wait_drain();

        // Operands changing after the handshake must not reach the core.
        grant_q.push_back(0);
        apply_stimulus(0, 8'd17, 8'd6, 16'd102);
        req0_a = 8'd99;
        req0_b = 8'd200;
        @(negedge sys_clk);
        #1;
        check_output("operand_hold_a", {24'd0, mult_a}, 32'd17);
        wait_drain();

        // Reset in the third enabled cycle aborts the operation with no response.
        grant_q.push_back(0);
        apply_stimulus(0, 8'd5, 8'd9, 16'd45);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        resp_q.delete();
        check_output("midrun_mult_en", {31'd0, mult_en}, 32'd0);
        check_output("midrun_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        check_output("midrun_rsp_data", {16'd0, rsp_data}, 32'd0);
        check_output("midrun_mult_a", {24'd0, mult_a}, 32'd0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        grant_q.push_back(1);
        apply_stimulus(1, 8'd2, 8'd3, 16'd6);
        wait_drain();
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            apply_stimulus(0, 8'd4, 8'd5, 16'd20);
            apply_stimulus(1, 8'd6, 8'd7, 16'd42);
        join
        wait_drain();

        check_output("grants_consumed", grant_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
